// File: rtl/interrupt_ctrl.sv
// Machine-mode trap sequencer: arbitrates mret/ecall/ebreak/interrupts in execute,
// strobes csrfile cause/epc/mstatus updates and redirects/flushes the pipeline.
module interrupt_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_in,
  input  logic                  reset_in,
  input  logic                  inst_valid_in,
  input  logic [ADDR_WIDTH-1:0] inst_addr_in,
  input  logic                  ecall_in,
  input  logic                  ebreak_in,
  input  logic                  mret_in,
  input  logic                  mstatus_mie_in,
  input  logic                  mip_meip_in,
  input  logic                  mip_msip_in,
  input  logic                  mip_mtip_in,
  input  logic                  mie_meie_in,
  input  logic                  mie_msie_in,
  input  logic                  mie_mtie_in,
  input  logic [DATA_WIDTH-1:0] mtvec_in,
  input  logic [ADDR_WIDTH-1:0] mepc_in,
  output logic                  interrupt_type_out,
  output logic                  cause_we_out,
  output logic [3:0]            trap_cause_out,
  output logic                  epc_we_out,
  output logic [ADDR_WIDTH-1:0] epc_out,
  output logic                  mstatus_ie_clear_out,
  output logic                  mstatus_ie_set_out,
  output logic                  stall_out,
  output logic                  flush_out,
  output logic                  redirect_valid_out,
  output logic [ADDR_WIDTH-1:0] redirect_pc_out
);

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    TRAP_SAVE = 2'b01,
    TRAP_JUMP = 2'b10,
    MRET_JUMP = 2'b11
  } state_e;

  state_e                  state_q, state_d;
  logic [3:0]              cause_q, cause_d;
  logic                    type_q, type_d;
  logic [ADDR_WIDTH-1:0]   epc_q, epc_d;
  logic [ADDR_WIDTH-1:0]   rpc_q, rpc_d;

  logic                    mei_s, msi_s, mti_s;
  logic                    mret_s, trap_s;
  logic [3:0]              det_cause_s;
  logic                    det_type_s;
  logic [DATA_WIDTH-1:0]   mtvec_base_s;
  logic [ADDR_WIDTH-1:0]   base_s, trap_pc_s, jump_pc_s;

  // Event qualification and fixed-priority cause selection
  always_comb begin
    mei_s       = mstatus_mie_in & mip_meip_in & mie_meie_in;
    msi_s       = mstatus_mie_in & mip_msip_in & mie_msie_in;
    mti_s       = mstatus_mie_in & mip_mtip_in & mie_mtie_in;
    mret_s      = inst_valid_in & mret_in;
    trap_s      = inst_valid_in & ~mret_in & (ecall_in | ebreak_in | mei_s | msi_s | mti_s);
    det_cause_s = 4'd0;
    det_type_s  = 1'b0;
    if (ecall_in) begin
      det_cause_s = 4'd11;
      det_type_s  = 1'b0;
    end else if (ebreak_in) begin
      det_cause_s = 4'd3;
      det_type_s  = 1'b0;
    end else if (mei_s) begin
      det_cause_s = 4'd11;
      det_type_s  = 1'b1;
    end else if (msi_s) begin
      det_cause_s = 4'd3;
      det_type_s  = 1'b1;
    end else if (mti_s) begin
      det_cause_s = 4'd7;
      det_type_s  = 1'b1;
    end else begin
      det_cause_s = 4'd0;
      det_type_s  = 1'b0;
    end
  end

  // Jump target: mtvec is read live in TRAP_JUMP, after csrfile has absorbed the save strobes
  always_comb begin
    mtvec_base_s = mtvec_in & ~DATA_WIDTH'(2'b11);
    base_s       = ADDR_WIDTH'(mtvec_base_s);
    if ((mtvec_in[1:0] == 2'b01) && type_q) begin
      trap_pc_s = base_s + ADDR_WIDTH'({cause_q, 2'b00});
    end else begin
      trap_pc_s = base_s;
    end
    case (state_q)
      TRAP_JUMP: jump_pc_s = trap_pc_s;
      MRET_JUMP: jump_pc_s = mepc_in;
      default:   jump_pc_s = rpc_q;
    endcase
  end

  // Next-state and latched trap context
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    type_d  = type_q;
    epc_d   = epc_q;
    rpc_d   = rpc_q;
    case (state_q)
      IDLE: begin
        if (mret_s) begin
          state_d = MRET_JUMP;
        end else if (trap_s) begin
          state_d = TRAP_SAVE;
          cause_d = det_cause_s;
          type_d  = det_type_s;
          epc_d   = inst_addr_in & ~ADDR_WIDTH'(2'b11);
        end else begin
          state_d = IDLE;
        end
      end
      TRAP_SAVE: state_d = TRAP_JUMP;
      TRAP_JUMP: begin
        state_d = IDLE;
        rpc_d   = jump_pc_s;
      end
      MRET_JUMP: begin
        state_d = IDLE;
        rpc_d   = jump_pc_s;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and context registers
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      state_q <= IDLE;
      cause_q <= 4'd0;
      type_q  <= 1'b0;
      epc_q   <= '0;
      rpc_q   <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      type_q  <= type_d;
      epc_q   <= epc_d;
      rpc_q   <= rpc_d;
    end
  end

  assign interrupt_type_out   = type_q;
  assign trap_cause_out       = cause_q;
  assign epc_out              = epc_q;
  assign cause_we_out         = (state_q == TRAP_SAVE);
  assign epc_we_out           = (state_q == TRAP_SAVE);
  assign mstatus_ie_clear_out = (state_q == TRAP_SAVE);
  assign mstatus_ie_set_out   = (state_q == MRET_JUMP);
  assign redirect_valid_out   = (state_q == TRAP_JUMP) | (state_q == MRET_JUMP);
  assign flush_out            = (state_q == TRAP_JUMP) | (state_q == MRET_JUMP);
  assign redirect_pc_out      = jump_pc_s;
  // Gated by reset so the combinational stall also reads 0 while reset is held
  assign stall_out            = reset_in & ((state_q != IDLE) | mret_s | trap_s);

endmodule

// File: tb/tb_interrupt_ctrl.sv
// Randomised and directed bench for interrupt_ctrl against a schedule-based reference model.
module tb_interrupt_ctrl;
  logic        clk_in = 1'b0;
  logic        reset_in = 1'b0;
  logic        inst_valid_in, ecall_in, ebreak_in, mret_in, mstatus_mie_in;
  logic        mip_meip_in, mip_msip_in, mip_mtip_in, mie_meie_in, mie_msie_in, mie_mtie_in;
  logic [31:0] inst_addr_in, mtvec_in, mepc_in;
  logic        interrupt_type_out, cause_we_out, epc_we_out, mstatus_ie_clear_out;
  logic        mstatus_ie_set_out, stall_out, flush_out, redirect_valid_out;
  logic [3:0]  trap_cause_out;
  logic [31:0] epc_out, redirect_pc_out;

  interrupt_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk_in(clk_in), .reset_in(reset_in), .inst_valid_in(inst_valid_in),
    .inst_addr_in(inst_addr_in), .ecall_in(ecall_in), .ebreak_in(ebreak_in),
    .mret_in(mret_in), .mstatus_mie_in(mstatus_mie_in), .mip_meip_in(mip_meip_in),
    .mip_msip_in(mip_msip_in), .mip_mtip_in(mip_mtip_in), .mie_meie_in(mie_meie_in),
    .mie_msie_in(mie_msie_in), .mie_mtie_in(mie_mtie_in), .mtvec_in(mtvec_in),
    .mepc_in(mepc_in), .interrupt_type_out(interrupt_type_out),
    .cause_we_out(cause_we_out), .trap_cause_out(trap_cause_out),
    .epc_we_out(epc_we_out), .epc_out(epc_out),
    .mstatus_ie_clear_out(mstatus_ie_clear_out), .mstatus_ie_set_out(mstatus_ie_set_out),
    .stall_out(stall_out), .flush_out(flush_out),
    .redirect_valid_out(redirect_valid_out), .redirect_pc_out(redirect_pc_out)
  );

  always #5 clk_in = ~clk_in;

  // Reference model: each detected event schedules the effects of the following cycles.
  typedef struct {bit save; bit tjump; bit mjump;} sched_t;
  sched_t      sched_q[$];
  logic [3:0]  m_cause = 4'd0;
  logic        m_type  = 1'b0;
  logic [31:0] m_epc   = 32'd0;
  int          err_cnt = 0;
  int          chk_cnt = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_check();
    sched_t      cur, s;
    bit          save_e, tj_e, mj_e, stall_e;
    int          c;
    bit          t;
    logic [31:0] base, tgt;
    save_e = 0; tj_e = 0; mj_e = 0; stall_e = 0; c = -1; t = 0; tgt = 32'd0;
    if (sched_q.size() > 0) begin
      cur = sched_q.pop_front();
      save_e = cur.save; tj_e = cur.tjump; mj_e = cur.mjump; stall_e = 1;
    end else if (inst_valid_in) begin
      if (mret_in) begin
        stall_e = 1;
        s = '{save: 1'b0, tjump: 1'b0, mjump: 1'b1};
        sched_q.push_back(s);
      end else begin
        if (ecall_in) c = 11;
        else if (ebreak_in) c = 3;
        else if (mstatus_mie_in && mip_meip_in && mie_meie_in) begin c = 11; t = 1; end
        else if (mstatus_mie_in && mip_msip_in && mie_msie_in) begin c = 3;  t = 1; end
        else if (mstatus_mie_in && mip_mtip_in && mie_mtie_in) begin c = 7;  t = 1; end
        if (c >= 0) begin
          stall_e = 1;
          s = '{save: 1'b1, tjump: 1'b0, mjump: 1'b0};
          sched_q.push_back(s);
          s = '{save: 1'b0, tjump: 1'b1, mjump: 1'b0};
          sched_q.push_back(s);
        end
      end
    end
    base = mtvec_in & 32'hFFFF_FFFC;
    if (tj_e) tgt = (mtvec_in[1:0] == 2'b01 && m_type) ? base + 32'(m_cause) * 32'd4 : base;
    if (mj_e) tgt = mepc_in;
    check_val("stall", stall_out, stall_e);
    check_val("cause_we", cause_we_out, save_e);
    check_val("epc_we", epc_we_out, save_e);
    check_val("ie_clear", mstatus_ie_clear_out, save_e);
    check_val("ie_set", mstatus_ie_set_out, mj_e);
    check_val("redir_valid", redirect_valid_out, tj_e | mj_e);
    check_val("flush", flush_out, tj_e | mj_e);
    check_val("cause", trap_cause_out, m_cause);
    check_val("type", interrupt_type_out, m_type);
    check_val("epc", epc_out, m_epc);
    if (tj_e || mj_e) check_val("redir_pc", redirect_pc_out, tgt);
    if (c >= 0) begin
      m_cause = 4'(c);
      m_type  = t;
      m_epc   = inst_addr_in & 32'hFFFF_FFFC;
    end
  endtask

  task automatic sample();
    @(negedge clk_in);
    model_check();
  endtask

  task automatic adv();
    @(posedge clk_in);
    #1;
  endtask

  task automatic quiet();
    inst_valid_in = 0; ecall_in = 0; ebreak_in = 0; mret_in = 0; mstatus_mie_in = 0;
    mip_meip_in = 0; mip_msip_in = 0; mip_mtip_in = 0;
    mie_meie_in = 0; mie_msie_in = 0; mie_mtie_in = 0;
    inst_addr_in = 32'd0; mtvec_in = 32'd0; mepc_in = 32'd0;
  endtask

  task automatic check_zero(input string tag);
    check_val({tag, "_stall"}, stall_out, 0);
    check_val({tag, "_cwe"}, cause_we_out, 0);
    check_val({tag, "_ewe"}, epc_we_out, 0);
    check_val({tag, "_clr"}, mstatus_ie_clear_out, 0);
    check_val({tag, "_set"}, mstatus_ie_set_out, 0);
    check_val({tag, "_rv"}, redirect_valid_out, 0);
    check_val({tag, "_flush"}, flush_out, 0);
    check_val({tag, "_cause"}, trap_cause_out, 0);
    check_val({tag, "_type"}, interrupt_type_out, 0);
    check_val({tag, "_epc"}, epc_out, 0);
    check_val({tag, "_rpc"}, redirect_pc_out, 0);
  endtask

  task automatic trap_seq(input string tag, input logic [3:0] ec, input logic et,
                          input logic [31:0] eepc, input logic [31:0] erpc);
    sample();
    check_val({tag, "_stallT"}, stall_out, 1);
    adv(); sample();
    check_val({tag, "_cweT1"}, cause_we_out, 1);
    check_val({tag, "_causeT1"}, trap_cause_out, ec);
    check_val({tag, "_typeT1"}, interrupt_type_out, et);
    check_val({tag, "_epcT1"}, epc_out, eepc);
    adv(); sample();
    check_val({tag, "_rvT2"}, redirect_valid_out, 1);
    check_val({tag, "_flushT2"}, flush_out, 1);
    check_val({tag, "_rpcT2"}, redirect_pc_out, erpc);
    adv();
  endtask

  initial begin
    quiet();
    inst_valid_in = 1; ecall_in = 1; mip_mtip_in = 1; mie_mtie_in = 1; mstatus_mie_in = 1;
    #12;
    check_zero("reset");
    quiet();
    @(posedge clk_in); #1;
    reset_in = 1;

    // Timer interrupt, direct mode
    mstatus_mie_in = 1; mie_mtie_in = 1; mip_mtip_in = 1; inst_valid_in = 1;
    inst_addr_in = 32'h100; mtvec_in = 32'h200;
    trap_seq("mti_direct", 4'd7, 1'b1, 32'h100, 32'h200);
    mtvec_in = 32'h201;
    trap_seq("mti_vec", 4'd7, 1'b1, 32'h100, 32'h21C);
    mip_meip_in = 1; mie_meie_in = 1; mip_msip_in = 1; mie_msie_in = 1;
    trap_seq("all_pend", 4'd11, 1'b1, 32'h100, 32'h22C);

    quiet();
    inst_valid_in = 1; ecall_in = 1; inst_addr_in = 32'h40; mtvec_in = 32'h201;
    mip_mtip_in = 1; mie_mtie_in = 1;
    trap_seq("ecall", 4'd11, 1'b0, 32'h40, 32'h200);

    // mret wins over a pending timer interrupt
    quiet();
    inst_valid_in = 1; mret_in = 1; mepc_in = 32'h104; mstatus_mie_in = 1;
    mip_mtip_in = 1; mie_mtie_in = 1; mtvec_in = 32'h200; inst_addr_in = 32'h80;
    sample();
    check_val("mret_stallT", stall_out, 1);
    adv(); sample();
    check_val("mret_setT1", mstatus_ie_set_out, 1);
    check_val("mret_rpcT1", redirect_pc_out, 32'h104);
    check_val("mret_flushT1", flush_out, 1);
    check_val("mret_cweT1", cause_we_out, 0);
    adv();
    mret_in = 0; mstatus_mie_in = 0; inst_addr_in = 32'h104;
    sample();
    check_val("mret_noirq", stall_out, 0);
    adv();
    mstatus_mie_in = 1;
    trap_seq("mret_irq", 4'd7, 1'b1, 32'h104, 32'h200);

    // Masked interrupt and invalid instruction
    mie_mtie_in = 0;
    sample(); check_val("masked_stall", stall_out, 0);
    adv(); sample(); check_val("masked_cwe", cause_we_out, 0);
    mie_mtie_in = 1; inst_valid_in = 0;
    adv(); sample(); check_val("novalid_stall", stall_out, 0);
    adv(); sample(); check_val("novalid_cwe", cause_we_out, 0);
    adv();

    // ecall pulsed during TRAP_SAVE is ignored
    inst_valid_in = 1; inst_addr_in = 32'h300;
    sample(); adv();
    ecall_in = 1;
    sample(); check_val("ign_cause", trap_cause_out, 7);
    adv();
    ecall_in = 0; inst_valid_in = 0;
    sample(); check_val("ign_rpc", redirect_pc_out, 32'h200);
    adv(); sample(); check_val("ign_after", cause_we_out, 0);
    adv();

    // Reset during TRAP_SAVE
    inst_valid_in = 1; inst_addr_in = 32'h500;
    sample(); adv();
    #2 reset_in = 0;
    #1 check_zero("midrst");
    sched_q.delete();
    m_cause = 4'd0; m_type = 1'b0; m_epc = 32'd0;
    quiet();
    @(posedge clk_in); #3;
    reset_in = 1;
    sample(); check_val("postrst_rv", redirect_valid_out, 0);
    adv(); sample(); check_val("postrst_rv2", redirect_valid_out, 0);
    adv();

    // Randomised traffic
    for (int i = 0; i < 600; i++) begin
      inst_valid_in  = ($urandom_range(0, 3) != 0);
      mret_in        = ($urandom_range(0, 9) == 0);
      ecall_in       = ($urandom_range(0, 9) == 0);
      ebreak_in      = ($urandom_range(0, 9) == 0);
      mstatus_mie_in = $urandom_range(0, 1);
      mip_meip_in    = ($urandom_range(0, 3) == 0);
      mip_msip_in    = ($urandom_range(0, 3) == 0);
      mip_mtip_in    = ($urandom_range(0, 3) == 0);
      mie_meie_in    = $urandom_range(0, 1);
      mie_msie_in    = $urandom_range(0, 1);
      mie_mtie_in    = $urandom_range(0, 1);
      inst_addr_in   = $urandom;
      mtvec_in       = $urandom;
      mepc_in        = $urandom;
      sample();
      adv();
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end
endmodule

// File: doc/interrupt_ctrl.md
# interrupt_ctrl

Machine-mode trap sequencer sitting between the execute stage and `csrfile`. It arbitrates pending interrupts (from csrfile's `mip`/`mie`/`mstatus.MIE` outputs) and synchronous `ecall`/`ebreak`/`mret` events from execute. It drives csrfile's cause/epc/mstatus update strobes, and redirects and flushes the pipeline to the trap vector or back to `mepc`.

## Interface
- `ADDR_WIDTH`, 32, PC/address width
- `DATA_WIDTH`, 32, CSR data width (mtvec)

- `clk_in`  in  1  clock, rising edge
- `reset_in`  in  1  asynchronous, active-low reset
- `inst_valid_in`  in  1  execute stage holds a valid, not-yet-retired instruction
- `inst_addr_in`  in  ADDR_WIDTH  PC of that instruction
- `ecall_in` / `ebreak_in` / `mret_in`  in  1 each  decoded in execute, qualified by `inst_valid_in`
- `mstatus_mie_in`  in  1  global M-mode interrupt enable
- `mip_meip_in`, `mip_msip_in`, `mip_mtip_in`  in  1 each  pending bits
- `mie_meie_in`, `mie_msie_in`, `mie_mtie_in`  in  1 each  enable bits
- `mtvec_in`  in  DATA_WIDTH  trap vector; [1:0]=mode
- `mepc_in`  in  ADDR_WIDTH  current mepc (mret target)
- `interrupt_type_out`  out  1  1=interrupt, 0=exception (to mcause[31])
- `cause_we_out`  out  1  mcause write strobe
- `trap_cause_out`  out  4  exception code
- `epc_we_out`  out  1  mepc write strobe
- `epc_out`  out  ADDR_WIDTH  value for mepc
- `mstatus_ie_clear_out`  out  1  MPIE<=MIE, MIE<=0
- `mstatus_ie_set_out`  out  1  MIE<=MPIE, MPIE<=1
- `stall_out`  out  1  hold IF/ID/EX
- `flush_out`  out  1  kill IF/ID/EX contents
- `redirect_valid_out`  out  1  load PC with `redirect_pc_out`
- `redirect_pc_out`  out  ADDR_WIDTH  new PC

## Operation
- States: IDLE, TRAP_SAVE, TRAP_JUMP, MRET_JUMP. Reset → IDLE.
- Detection occurs in IDLE only, with `inst_valid_in`=1. Priority, highest first:
  - mret
  - ecall (cause 11, type 0)
  - ebreak (cause 3, type 0)
  - MEI (11, type 1)
  - MSI (3, type 1)
  - MTI (7, type 1)
- An interrupt is taken only if `mstatus_mie_in` & `mip_x` & `mie_x`. Sync events ignore `mstatus_mie_in`.
- On trap detect: latch `trap_cause_out`, `interrupt_type_out`, and `epc_out`=`{inst_addr_in[ADDR_WIDTH-1:2],2'b00}`. The PC of the trapping/interrupted instruction is used, because that instruction is flushed and does not retire. Then → TRAP_SAVE.
- TRAP_SAVE: `cause_we_out`=`epc_we_out`=`mstatus_ie_clear_out`=1 for this cycle only. → TRAP_JUMP.
- TRAP_JUMP: `redirect_valid_out`=`flush_out`=1. → IDLE.
  - Redirect target when mtvec[1:0]=01 and type=1: base + 4·cause.
  - Otherwise: base.
  - base={mtvec_in[DATA_WIDTH-1:2],2'b00}.
- On mret detect → MRET_JUMP: `mstatus_ie_set_out`=`redirect_valid_out`=`flush_out`=1, `redirect_pc_out`=`mepc_in`. → IDLE.
- `stall_out` = (state≠IDLE) | (IDLE & event detected this cycle). It is combinational; all other outputs are registered/state-decoded.
- Events present while state≠IDLE are ignored; the pipeline is stalled, so they are re-presented later.
- `redirect_pc_out` and `trap_cause_out` hold their last value when not strobed; `redirect_pc_out` is don't-care when `redirect_valid_out`=0.
- Target addition wraps modulo 2^ADDR_WIDTH.

## Timing
- Reset (async assert, sync release): state=IDLE; every output 0.
- Reset mid-sequence aborts it immediately; no further strobes are issued.
- Trap: detect cycle T (`stall_out`=1), strobes in T+1, redirect/flush in T+2, IDLE at T+3.
  - csrfile registers mcause/mepc/MIE at the end of T+1, so `mtvec_in` is sampled in T+2.
- mret: detect T, set/redirect/flush in T+1, IDLE at T+2.
- Back-to-back: a new event can be detected at T+3 (trap) or T+2 (mret). MIE is already 0 after a trap, so no interrupt nesting occurs unless software re-enables MIE.
- Simultaneous mret + pending interrupt: mret wins. The interrupt is re-evaluated after MIE restore.

## Test plan
- Reset released, mstatus_mie=1, mie_mtie=1, mip_mtip=1, inst_valid=1, pc=0x100, mtvec=0x200 → T+1: cause_we/epc_we/ie_clear=1, cause=7, type=1, epc=0x100; T+2: redirect_pc=0x200, flush=1.
- Same trap with mtvec=0x201 (vectored) → redirect_pc=0x21C. With MEI+MSI+MTI all pending → cause=11, redirect_pc=0x22C.
- ecall at pc=0x40, mstatus_mie=0 → cause=11, type=0, epc=0x40, redirect_pc=base.
- mret with mepc=0x104, plus MTI pending at the same time → T+1: ie_set=1, redirect_pc=0x104, flush=1; no cause_we in T+1; the interrupt is taken later only once MIE=1.
- Interrupt pending with mie bit clear or inst_valid=0 → no stall, no strobes. Pulse ecall during TRAP_SAVE → ignored.
- Assert reset_in=0 during TRAP_SAVE → all outputs 0 asynchronously; after release, state is IDLE and no redirect occurs.
